// File: rtl/data_memory_pkg.sv
// Shared defaults, FSM encoding and port identifiers for the data memory arbiter.
package data_memory_pkg;

  localparam int unsigned RAM_WIDTH_DEF     = 16;
  localparam int unsigned RAM_ADDR_BITS_DEF = 11;
  localparam int unsigned MAX_WAIT_DEF      = 4;
  localparam int unsigned WAIT_CNT_W        = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCK_B = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

endpackage

// File: rtl/data_memory.sv
// Single-port synchronous RAM: write on the rising edge, registered read data.
module data_memory #(
  parameter int unsigned RAM_WIDTH     = 16,
  parameter int unsigned RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     write,
  input  logic [RAM_ADDR_BITS-1:0] addr_data,
  input  logic [RAM_WIDTH-1:0]     in_data,
  output logic [RAM_WIDTH-1:0]     out_data
);

  localparam int unsigned DEPTH = 1 << RAM_ADDR_BITS;

  logic [RAM_WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (write) begin
      ram[addr_data] <= in_data;
    end
    out_data <= ram[addr_data];
  end

endmodule

// File: rtl/data_memory_wait_counter.sv
// Saturating count of consecutive cycles port B has been refused.
module data_memory_wait_counter
  import data_memory_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  b_req,
  input  logic                  b_gnt,
  input  logic                  hold_zero,
  output logic [WAIT_CNT_W-1:0] cnt,
  output logic                  at_max
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hold_zero || !b_req || b_gnt) begin
      cnt <= '0;
    end else if (cnt != MAX_CNT) begin
      cnt <= cnt + WAIT_CNT_W'(1);
    end
  end

  assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of data_memory: pipeline port A, debug port B with
// starvation bound and lock, one access per cycle, one-cycle read latency.
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int unsigned RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int unsigned MAX_WAIT      = MAX_WAIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_req,
  input  logic                     a_write,
  input  logic [RAM_ADDR_BITS-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0]     a_wdata,
  output logic                     a_gnt,
  output logic                     a_rvalid,
  output logic [RAM_WIDTH-1:0]     a_rdata,
  input  logic                     b_req,
  input  logic                     b_write,
  input  logic [RAM_ADDR_BITS-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0]     b_wdata,
  input  logic                     b_lock,
  output logic                     b_gnt,
  output logic                     b_rvalid,
  output logic [RAM_WIDTH-1:0]     b_rdata,
  output logic                     mem_write,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  input  logic [RAM_WIDTH-1:0]     mem_rdata
);

  arb_state_t            state;
  logic                  lock_mode;
  logic                  wait_at_max;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  rd_valid;
  port_id_t              rd_owner;

  data_memory_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .b_req     (b_req),
    .b_gnt     (b_gnt),
    .hold_zero (lock_mode),
    .cnt       (wait_cnt),
    .at_max    (wait_at_max)
  );

  // A cycle in LOCK_B with b_lock low is arbitrated as ARB.
  assign lock_mode = (state == LOCK_B) && b_lock;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (lock_mode) begin
        b_gnt = b_req;
      end else begin
        b_gnt = b_req && (!a_req || wait_at_max);
        a_gnt = a_req && !b_gnt;
      end
    end
  end

  always_comb begin
    mem_write = 1'b0;
    mem_addr  = a_addr;
    mem_wdata = a_wdata;
    if (b_gnt) begin
      mem_write = b_write;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end else if (a_gnt) begin
      mem_write = a_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else if (lock_mode || (b_gnt && b_lock)) begin
      state <= LOCK_B;
    end else begin
      state <= ARB;
    end
  end

  // Remember who issued the read so the returning word is steered correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_owner <= PORT_A;
    end else begin
      rd_valid <= (a_gnt && !a_write) || (b_gnt && !b_write);
      if (b_gnt && !b_write) begin
        rd_owner <= PORT_B;
      end else if (a_gnt && !a_write) begin
        rd_owner <= PORT_A;
      end
    end
  end

  assign a_rvalid = rd_valid && (rd_owner == PORT_A);
  assign b_rvalid = rd_valid && (rd_owner == PORT_B);
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench: directed vector table, reset sequences, and random traffic
// against a transaction-level model of the arbiter plus memory.
module tb_data_memory_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned AB = 11;
  localparam int unsigned MW = 4;

  logic          clk, rst_n;
  logic          a_req, a_write, a_gnt, a_rvalid;
  logic [AB-1:0] a_addr;
  logic [W-1:0]  a_wdata, a_rdata;
  logic          b_req, b_write, b_lock, b_gnt, b_rvalid;
  logic [AB-1:0] b_addr;
  logic [W-1:0]  b_wdata, b_rdata;
  logic          mem_write;
  logic [AB-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  data_memory_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  data_memory #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) u_mem (
    .clk(clk), .write(mem_write), .addr_data(mem_addr),
    .in_data(mem_wdata), .out_data(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          a_req, a_write;
    logic [AB-1:0] a_addr;
    logic [W-1:0]  a_wdata;
    logic          b_req, b_write, b_lock;
    logic [AB-1:0] b_addr;
    logic [W-1:0]  b_wdata;
    logic          ea, eb, eav, ebv;
    logic [W-1:0]  erd;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic ar, logic aw, logic [AB-1:0] aa, logic [W-1:0] ad,
                              logic br, logic bw, logic bl, logic [AB-1:0] ba,
                              logic [W-1:0] bd, logic ea, logic eb, logic eav,
                              logic ebv, logic [W-1:0] erd);
    vec_t v;
    v.a_req = ar; v.a_write = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_write = bw; v.b_lock = bl; v.b_addr = ba; v.b_wdata = bd;
    v.ea = ea; v.eb = eb; v.eav = eav; v.ebv = ebv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit           m_lock;
  int           m_wcnt;
  bit           pend_v, pend_port, pend_known;
  logic [W-1:0] pend_data;
  logic [W-1:0] mmem [1 << AB];
  bit           known [1 << AB];

  task automatic set_idle();
    a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_write = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  // Compare one cycle against the model, advance the model over the rising edge.
  task automatic cycle_check(output bit ea, output bit eb);
    bit el, ew;
    logic [AB-1:0] ad;
    logic [W-1:0]  wd;
    el = m_lock && b_lock;
    if (el) begin
      eb = b_req; ea = 0;
    end else begin
      eb = b_req && (!a_req || m_wcnt == MW);
      ea = a_req && !eb;
    end
    ad = eb ? b_addr : a_addr;
    wd = eb ? b_wdata : a_wdata;
    ew = eb ? b_write : (ea ? a_write : 1'b0);
    #1;
    chk("a_gnt", 32'(a_gnt), 32'(ea));
    chk("b_gnt", 32'(b_gnt), 32'(eb));
    chk("mem_write", 32'(mem_write), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ad));
    chk("mem_wdata", 32'(mem_wdata), 32'(wd));
    chk("a_rvalid", 32'(a_rvalid), 32'(pend_v && !pend_port));
    chk("b_rvalid", 32'(b_rvalid), 32'(pend_v && pend_port));
    if (pend_v && pend_known)
      chk("rdata", 32'(pend_port ? b_rdata : a_rdata), 32'(pend_data));
    pend_v     = (ea || eb) && !ew;
    pend_port  = eb;
    pend_data  = mmem[ad];
    pend_known = known[ad];
    if (ew) begin
      mmem[ad]  = wd;
      known[ad] = 1;
    end
    if (!b_req || eb) m_wcnt = 0;
    else if (m_wcnt < MW) m_wcnt = m_wcnt + 1;
    m_lock = el || (eb && b_lock);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_reset();
    rst_n = 0;
    #1;
    chk("rst a_gnt", 32'(a_gnt), 0);
    chk("rst b_gnt", 32'(b_gnt), 0);
    chk("rst mem_write", 32'(mem_write), 0);
    chk("rst a_rvalid", 32'(a_rvalid), 0);
    chk("rst b_rvalid", 32'(b_rvalid), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_lock = 0; m_wcnt = 0; pend_v = 0;
  endtask

  function automatic logic [AB-1:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return AB'(11'h7FF);
    return AB'($urandom_range(0, 7));
  endfunction

  initial begin
    bit ea, eb, a_pend, b_pend;
    rst_n = 0;
    set_idle();
    a_req = 1; a_write = 1; b_req = 1; b_write = 1;
    #1;
    chk("reset a_gnt", 32'(a_gnt), 0);
    chk("reset b_gnt", 32'(b_gnt), 0);
    chk("reset mem_write", 32'(mem_write), 0);
    chk("reset a_rvalid", 32'(a_rvalid), 0);
    chk("reset b_rvalid", 32'(b_rvalid), 0);
    chk("reset state", 32'(dut.state), 0);
    chk("reset wait_cnt", 32'(dut.wait_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    set_idle();

    // Directed vectors: each row is one cycle (inputs, grants, read return).
    tbl[0]  = mk(1, 1, 11'h005, 16'h1234, 0, 0, 0, 11'h000, 16'h0000, 1, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 0, 11'h005, 16'h0000, 0, 0, 0, 11'h000, 16'h0000, 1, 0, 0, 0, 16'h0000);
    tbl[2]  = mk(0, 0, 11'h000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 1, 0, 16'h1234);
    tbl[3]  = mk(1, 1, 11'h010, 16'h1111, 0, 0, 0, 11'h000, 16'h0000, 1, 0, 0, 0, 16'h0000);
    tbl[4]  = mk(0, 0, 11'h000, 16'h0000, 1, 1, 0, 11'h020, 16'h2222, 0, 1, 0, 0, 16'h0000);
    tbl[5]  = mk(1, 0, 11'h010, 16'h0000, 0, 0, 0, 11'h000, 16'h0000, 1, 0, 0, 0, 16'h0000);
    tbl[6]  = mk(0, 0, 11'h000, 16'h0000, 1, 0, 0, 11'h020, 16'h0000, 0, 1, 1, 0, 16'h1111);
    tbl[7]  = mk(0, 0, 11'h000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 0, 1, 16'h2222);
    tbl[8]  = mk(1, 0, 11'h005, 16'h0000, 1, 0, 0, 11'h010, 16'h0000, 1, 0, 0, 0, 16'h0000);
    tbl[9]  = mk(1, 0, 11'h005, 16'h0000, 1, 0, 0, 11'h010, 16'h0000, 1, 0, 1, 0, 16'h1234);
    tbl[10] = mk(1, 0, 11'h005, 16'h0000, 1, 0, 0, 11'h010, 16'h0000, 1, 0, 1, 0, 16'h1234);
    tbl[11] = mk(1, 0, 11'h005, 16'h0000, 1, 0, 0, 11'h010, 16'h0000, 1, 0, 1, 0, 16'h1234);
    tbl[12] = mk(1, 0, 11'h005, 16'h0000, 1, 0, 0, 11'h010, 16'h0000, 0, 1, 1, 0, 16'h1234);
    tbl[13] = mk(1, 0, 11'h005, 16'h0000, 1, 0, 0, 11'h010, 16'h0000, 1, 0, 0, 1, 16'h1111);
    tbl[14] = mk(0, 0, 11'h000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 1, 0, 16'h1234);
    tbl[15] = mk(0, 0, 11'h000, 16'h0000, 1, 1, 1, 11'h7FF, 16'h00AA, 0, 1, 0, 0, 16'h0000);
    tbl[16] = mk(1, 0, 11'h7FF, 16'h0000, 0, 0, 1, 11'h000, 16'h0000, 0, 0, 0, 0, 16'h0000);
    tbl[17] = mk(1, 0, 11'h7FF, 16'h0000, 1, 0, 1, 11'h7FF, 16'h0000, 0, 1, 0, 0, 16'h0000);
    tbl[18] = mk(1, 0, 11'h7FF, 16'h0000, 0, 0, 0, 11'h000, 16'h0000, 1, 0, 0, 1, 16'h00AA);
    tbl[19] = mk(0, 0, 11'h000, 16'h0000, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 1, 0, 16'h00AA);

    for (int i = 0; i < 20; i++) begin
      a_req = tbl[i].a_req; a_write = tbl[i].a_write;
      a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wdata;
      b_req = tbl[i].b_req; b_write = tbl[i].b_write; b_lock = tbl[i].b_lock;
      b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wdata;
      #1;
      chk($sformatf("vec%0d a_gnt", i), 32'(a_gnt), 32'(tbl[i].ea));
      chk($sformatf("vec%0d b_gnt", i), 32'(b_gnt), 32'(tbl[i].eb));
      chk($sformatf("vec%0d a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].eav));
      chk($sformatf("vec%0d b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].ebv));
      if (tbl[i].eav) chk($sformatf("vec%0d a_rdata", i), 32'(a_rdata), 32'(tbl[i].erd));
      if (tbl[i].ebv) chk($sformatf("vec%0d b_rdata", i), 32'(b_rdata), 32'(tbl[i].erd));
      @(posedge clk);
      @(negedge clk);
    end

    // Reset right after an A read grant discards the pending return.
    set_idle();
    a_req = 1; a_addr = 11'h005;
    #1 chk("pre-rst a_gnt", 32'(a_gnt), 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    a_write = 1; b_req = 1; b_write = 1;
    #1;
    chk("midrst a_rvalid", 32'(a_rvalid), 0);
    chk("midrst a_gnt", 32'(a_gnt), 0);
    chk("midrst b_gnt", 32'(b_gnt), 0);
    chk("midrst mem_write", 32'(mem_write), 0);
    chk("midrst state", 32'(dut.state), 0);
    chk("midrst wait_cnt", 32'(dut.wait_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst a_rvalid hold", 32'(a_rvalid), 0);
    rst_n = 1;
    set_idle();
    a_req = 1; a_addr = 11'h005;
    #1 chk("postrst a_gnt", 32'(a_gnt), 1);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
    chk("postrst a_rvalid", 32'(a_rvalid), 1);
    chk("postrst a_rdata", 32'(a_rdata), 32'h1234);

    // Reset while B holds the lock releases it.
    @(negedge clk);
    b_req = 1; b_write = 1; b_lock = 1; b_addr = 11'h7FF; b_wdata = 16'h0055;
    #1 chk("lock b_gnt", 32'(b_gnt), 1);
    @(posedge clk);
    @(negedge clk);
    b_req = 0; b_write = 0; a_req = 1; a_addr = 11'h7FF;
    #1 chk("locked a_gnt", 32'(a_gnt), 0);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1 chk("unlocked a_gnt", 32'(a_gnt), 1);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
    chk("unlocked a_rvalid", 32'(a_rvalid), 1);
    chk("unlocked a_rdata", 32'(a_rdata), 32'h0055);
    @(negedge clk);

    // Random traffic against the model; requesters mostly hold until granted.
    for (int i = 0; i < (1 << AB); i++) known[i] = 0;
    a_pend = 0; b_pend = 0;
    rand_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rand_reset();
        a_pend = 0; b_pend = 0;
      end else begin
        if (!a_pend || $urandom_range(0, 15) == 0) begin
          a_req = ($urandom_range(0, 9) < 6); a_write = $urandom_range(0, 1) == 1;
          a_addr = rnd_addr(); a_wdata = W'($urandom);
        end
        if (!b_pend || $urandom_range(0, 15) == 0) begin
          b_req = ($urandom_range(0, 9) < 4); b_write = $urandom_range(0, 1) == 1;
          b_addr = rnd_addr(); b_wdata = W'($urandom);
        end
        if ($urandom_range(0, 7) == 0) b_lock = ~b_lock;
        cycle_check(ea, eb);
        a_pend = a_req && !ea;
        b_pend = b_req && !eb;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
